mig_tt_engine: RTL and testbench
================================

// Module: mig_tt_engine
// PURPOSE
//  Programmable majority(-inverter) network evaluator. Holds a loadable netlist of NUM_NODES
//  3-input majority nodes over NUM_INPUTS primary inputs, sweeps all 2^NUM_INPUTS minterms
//  (one per cycle) and returns the complete truth table of a selected node. Sits beside the
//  classification flow to produce canonical truth tables without per-function RTL.
// PARAMETERS
//  NUM_INPUTS  7   primary inputs x0..x(N-1); truth table width TT_W = 2^NUM_INPUTS
//  NUM_NODES   8   majority nodes n0..n(M-1); NODE_W = clog2(NUM_NODES)
//  (derived)   SEL_W = clog2(NUM_INPUTS+NUM_NODES+1): operand index width
// PORTS
//  clk        in   1       clock, all logic rising-edge
//  rst        in   1       synchronous, active-high reset
//  cfg_we     in   1       write node config (ignored while busy)
//  cfg_node   in   NODE_W  node index to write
//  cfg_sel_a  in   SEL_W   operand A index; cfg_sel_b / cfg_sel_c same width, operands B / C
//  cfg_inv    in   3       per-operand complement {c,b,a} (MIG_COMPL_EN only)
//  out_sel    in   NODE_W  node whose value forms tt; sampled when start accepted
//  start      in   1       begin sweep (accepted only when busy=0)
//  busy       out  1       high from cycle after start accepted until done cycle inclusive
//  done       out  1       one-cycle pulse: tt complete
//  tt         out  TT_W    truth table, tt[m] = f(minterm m), x_i = bit i of m
// BEHAVIOUR
//  Reset: busy=0, done=0, tt=0, minterm counter=0, FSM=IDLE, all node configs cleared
//   (sel=0, inv=0 -> every node = MAJ(0,0,0) = 0). Reset mid-sweep aborts, no done pulse.
//  Operand index: 0 = const 0; 1..NUM_INPUTS = x(idx-1); NUM_INPUTS+1+j = node j.
//   Node j may reference only const/inputs/nodes k<j; index >= NUM_INPUTS+1+j (forward or
//   self ref) or out of range evaluates as const 0. Network is acyclic by construction.
//  Node value: MAJ(a,b,c) = ab|ac|bc on (optionally complemented) operands.
//  FSM: IDLE --start--> EVAL --m==TT_W-1--> DONE --> IDLE.
//   IDLE: busy=0; cfg writes applied next edge; start latches out_sel, clears counter.
//   EVAL: network evaluated combinationally for counter m; tt[m] written at edge; m++.
//   DONE: done=1 for exactly one cycle, busy=1; next cycle IDLE.
//  Latency: start accepted at edge k -> done high in cycle k+TT_W+1 (TT_W EVAL + 1 DONE).
//  tt bits not yet written during EVAL keep previous sweep values; tt stable from done until
//   next accepted start. Counter is NODE-independent, width NUM_INPUTS, no wrap past TT_W-1.
//  Simultaneous cfg_we and start in IDLE: config write lands, sweep uses new config.
//  start or cfg_we while busy: ignored, no side effects. Config stays valid across sweeps.
// CONFIGURATION
//  MIG_COMPL_EN defined: cfg_inv stored per node; operand = raw ^ inv bit (inverted const 0
//   gives const 1). Undefined: no inv storage, cfg_inv ignored, pure majority network.
// TESTING
//  T1 n0=MAJ(x0,x1,x2) (sel 1,2,3), out_sel=0, start -> done at start+129, tt={16{8'hE8}}.
//  T2 n0=MAJ(x0,x1,0) -> tt={16{8'h88}}; n1=MAJ(n0,x2,0) (sel 8,3,0), out_sel=1 -> {16{8'h80}}.
//  T3 MIG_COMPL_EN: n0=MAJ(x0,x1,~0) -> tt={32{4'hE}}; same cfg without macro -> {16{8'h88}}.
//  T4 n0 sel_a=9 (forward ref to n1), sel_b=1, sel_c=2 -> treated const 0 -> tt={16{8'h88}}.
//  T5 start and cfg_we pulsed at cycle 40 of sweep -> ignored; tt/done per T1; busy=1 throughout.
//  T6 rst at cycle 60 of sweep -> busy=0, tt=0, no done; new cfg+start -> correct tt.

Source files
------------

// File: rtl/mig_tt_engine.sv
// mig_tt_engine: programmable majority(-inverter) network evaluator.
// Holds NUM_NODES configurable 3-input majority nodes over NUM_INPUTS primary
// inputs, sweeps every minterm (one per cycle) and assembles the truth table
// of a selected node.
// Optional feature macro: MIG_COMPL_EN adds per-operand complement storage.
//
// Handshake: start is a single-cycle request, accepted only when busy=0.
// busy stays high from the cycle after acceptance through the done cycle;
// done is a one-cycle pulse, and tt is stable from done until the next
// accepted start. cfg_we is honoured only while idle.
module mig_tt_engine #(
  parameter int NUM_INPUTS = 7,
  parameter int NUM_NODES  = 8,
  localparam int TT_W   = 2 ** NUM_INPUTS,
  localparam int NODE_W = $clog2(NUM_NODES),
  localparam int SEL_W  = $clog2(NUM_INPUTS + NUM_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [NODE_W-1:0] cfg_node,
  input  logic [SEL_W-1:0]  cfg_sel_a,
  input  logic [SEL_W-1:0]  cfg_sel_b,
  input  logic [SEL_W-1:0]  cfg_sel_c,
  input  logic [2:0]        cfg_inv,
  input  logic [NODE_W-1:0] out_sel,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   tt,
  output logic [1:0]        dbg_state
);

  localparam int XI_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [NUM_INPUTS-1:0] LAST_M = {NUM_INPUTS{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    DONE_S = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SEL_W-1:0]      sel_a_q [NUM_NODES];
  logic [SEL_W-1:0]      sel_b_q [NUM_NODES];
  logic [SEL_W-1:0]      sel_c_q [NUM_NODES];
`ifdef MIG_COMPL_EN
  logic [2:0]            inv_q   [NUM_NODES];
`else
  logic                  unused_cfg_inv;
  assign unused_cfg_inv = ^cfg_inv;
`endif
  logic [NUM_INPUTS-1:0] cnt_q;
  logic [NODE_W-1:0]     out_sel_q;
  logic [NUM_NODES-1:0]  node_val;

  assign dbg_state = state_q;

  // Operand fetch: 0 = const 0, 1..N = inputs, then nodes below j only.
  // Anything else (self/forward ref, out of range) reads as const 0, which
  // keeps the network acyclic regardless of what gets programmed.
  function automatic logic opnd(input logic [SEL_W-1:0] sel, input int j,
                                input logic [NUM_INPUTS-1:0] x,
                                input logic [NUM_NODES-1:0] v);
    int idx;
    idx = int'(sel);
    if (idx == 0)
      return 1'b0;
    else if (idx <= NUM_INPUTS)
      return x[XI_W'(idx - 1)];
    else if (idx < NUM_INPUTS + 1 + j)
      return v[NODE_W'(idx - NUM_INPUTS - 1)];
    else
      return 1'b0;
  endfunction

  // Evaluate the whole network for the current minterm in node order.
  always_comb begin
    logic [NUM_NODES-1:0] v;
    logic a, b, c;
    v = '0;
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    for (int j = 0; j < NUM_NODES; j++) begin
      a = opnd(sel_a_q[j], j, cnt_q, v);
      b = opnd(sel_b_q[j], j, cnt_q, v);
      c = opnd(sel_c_q[j], j, cnt_q, v);
`ifdef MIG_COMPL_EN
      a = a ^ inv_q[j][0];
      b = b ^ inv_q[j][1];
      c = c ^ inv_q[j][2];
`endif
      v[j] = (a & b) | (a & c) | (b & c);
    end
    node_val = v;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = EVAL;
      end
      EVAL: begin
        busy = 1'b1;
        if (cnt_q == LAST_M) state_d = DONE_S;
      end
      DONE_S: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Node configuration: written only while idle, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NUM_NODES; j++) begin
        sel_a_q[j] <= '0;
        sel_b_q[j] <= '0;
        sel_c_q[j] <= '0;
`ifdef MIG_COMPL_EN
        inv_q[j]   <= '0;
`endif
      end
    end else if (state_q == IDLE && cfg_we) begin
      sel_a_q[cfg_node] <= cfg_sel_a;
      sel_b_q[cfg_node] <= cfg_sel_b;
      sel_c_q[cfg_node] <= cfg_sel_c;
`ifdef MIG_COMPL_EN
      inv_q[cfg_node]   <= cfg_inv;
`endif
    end
  end

  // Sweep datapath: latch output node on start, write one tt bit per EVAL
  // cycle; the counter parks at the last minterm instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      out_sel_q <= '0;
      tt        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q     <= '0;
            out_sel_q <= out_sel;
          end
        end
        EVAL: begin
          tt[cnt_q] <= node_val[out_sel_q];
          if (cnt_q != LAST_M) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mig_tt_engine.sv
// Bench for mig_tt_engine: directed sweeps, expected truth tables queued by
// the driver and compared by a monitor whenever done pulses.
module tb_mig_tt_engine;

  localparam int TT_W = 128;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_we;
  logic [2:0]   cfg_node;
  logic [3:0]   cfg_sel_a, cfg_sel_b, cfg_sel_c;
  logic [2:0]   cfg_inv;
  logic [2:0]   out_sel;
  logic         start;
  logic         busy, done;
  logic [127:0] tt;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [TT_W-1:0] exp_q[$];

  mig_tt_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_node(cfg_node),
    .cfg_sel_a(cfg_sel_a), .cfg_sel_b(cfg_sel_b), .cfg_sel_c(cfg_sel_c),
    .cfg_inv(cfg_inv), .out_sel(out_sel), .start(start),
    .busy(busy), .done(done), .tt(tt), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [TT_W-1:0] act,
                       input logic [TT_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // monitor / scoreboard: every done pulse must match the next queued table
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: tt %h with no sweep outstanding", tt);
      end else begin
        logic [TT_W-1:0] e;
        e = exp_q.pop_front();
        if (tt !== e) begin
          errors++;
          $display("FAIL tt_compare: got %h expected %h", tt, e);
        end
      end
    end
  end

  task automatic set_cfg(input logic [2:0] node, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c,
                         input logic [2:0] inv);
    cfg_node  = node;
    cfg_sel_a = a;
    cfg_sel_b = b;
    cfg_sel_c = c;
    cfg_inv   = inv;
  endtask

  task automatic write_cfg(input logic [2:0] node, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c,
                           input logic [2:0] inv);
    @(negedge clk);
    set_cfg(node, a, b, c, inv);
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Run one sweep. disturb_at / abort_at are EVAL-cycle indices (-1 = off).
  // with_cfg pulses cfg_we together with start (cfg fields preset by caller).
  task automatic sweep(input string name, input logic [2:0] osel,
                       input logic [TT_W-1:0] exp, input int disturb_at,
                       input int abort_at, input bit with_cfg);
    int n;
    bit got, busy_ok;
    @(negedge clk);
    start   = 1'b1;
    out_sel = osel;
    if (with_cfg) cfg_we = 1'b1;
    if (abort_at < 0) exp_q.push_back(exp);
    @(negedge clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    n = 0; got = 0; busy_ok = 1;
    // first EVAL cycle already sampled at this negedge
    while (n < 200) begin
      if (done) begin got = 1; break; end
      if (!busy) busy_ok = 0;
      if (n == disturb_at) begin
        start = 1'b1; cfg_we = 1'b1; out_sel = 3'd5;
        set_cfg(3'd0, 4'd0, 4'd0, 4'd0, 3'b111);
      end
      if (n == disturb_at + 1) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      n++;
      @(negedge clk);
    end
    if (abort_at >= 0) begin
      check({name, "_abort_busy"}, TT_W'(busy), TT_W'(1'b0));
      check({name, "_abort_done"}, TT_W'(done), TT_W'(1'b0));
      check({name, "_abort_tt"}, tt, '0);
      repeat (140) @(negedge clk);
      check({name, "_abort_no_done_busy"}, TT_W'(busy), TT_W'(1'b0));
    end else begin
      check({name, "_done_seen"}, TT_W'(got), TT_W'(1'b1));
      check({name, "_latency"}, TT_W'(n), TT_W'(TT_W));
      check({name, "_busy_during"}, TT_W'(busy_ok), TT_W'(1'b1));
      check({name, "_busy_at_done"}, TT_W'(busy), TT_W'(1'b1));
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; out_sel = '0;
    set_cfg(3'd0, 4'd0, 4'd0, 4'd0, 3'b000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_tt", tt, '0);
    check("reset_busy", TT_W'(busy), TT_W'(1'b0));
    check("reset_done", TT_W'(done), TT_W'(1'b0));

    // T1: n0 = MAJ(x0,x1,x2)
    write_cfg(3'd0, 4'd1, 4'd2, 4'd3, 3'b000);
    sweep("t1", 3'd0, {16{8'hE8}}, -1, -1, 0);

    // T2: n0 = x0&x1, n1 = MAJ(n0,x2,0) = x0&x1&x2
    write_cfg(3'd0, 4'd1, 4'd2, 4'd0, 3'b000);
    write_cfg(3'd1, 4'd8, 4'd3, 4'd0, 3'b000);
    sweep("t2_n0", 3'd0, {16{8'h88}}, -1, -1, 0);
    sweep("t2_n1", 3'd1, {16{8'h80}}, -1, -1, 0);

    // T3: n0 = MAJ(x0,x1,~0) when complement supported, else plain x0&x1
    write_cfg(3'd0, 4'd1, 4'd2, 4'd0, 3'b100);
`ifdef MIG_COMPL_EN
    sweep("t3", 3'd0, {32{4'hE}}, -1, -1, 0);
`else
    sweep("t3", 3'd0, {16{8'h88}}, -1, -1, 0);
`endif

    // T4: forward reference to n1 reads as const 0
    write_cfg(3'd0, 4'd9, 4'd1, 4'd2, 3'b000);
    sweep("t4", 3'd0, {16{8'h88}}, -1, -1, 0);

    // top input and self-reference on the last node
    write_cfg(3'd2, 4'd7, 4'd7, 4'd0, 3'b000);
    sweep("x6", 3'd2, {{64{1'b1}}, {64{1'b0}}}, -1, -1, 0);
    write_cfg(3'd7, 4'd15, 4'd1, 4'd1, 3'b000);
    sweep("self_ref", 3'd7, {64{2'b10}}, -1, -1, 0);

    // simultaneous cfg_we and start in IDLE: sweep uses the new config
    set_cfg(3'd0, 4'd1, 4'd2, 4'd3, 3'b000);
    sweep("cfg_and_start", 3'd0, {16{8'hE8}}, -1, -1, 1);

    // T5: start/cfg_we mid-sweep ignored; config unchanged for next sweep
    sweep("t5", 3'd0, {16{8'hE8}}, 40, -1, 0);
    sweep("t5_after", 3'd0, {16{8'hE8}}, -1, -1, 0);

    // T6: reset mid-sweep, then configs are cleared, then new cfg works
    sweep("t6", 3'd0, '0, -1, 60, 0);
    sweep("t6_cleared", 3'd1, '0, -1, -1, 0);
    write_cfg(3'd0, 4'd1, 4'd2, 4'd3, 3'b000);
    sweep("t6_new", 3'd0, {16{8'hE8}}, -1, -1, 0);

    repeat (3) @(negedge clk);
    check("queue_empty", TT_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
